// File: rtl/count_checker.sv
// rtl/count_checker.sv - free-running counter checker with lock acquisition and error counting
//
// Optional feature macro: COUNT_CHECKER_STICKY_EN adds the err_sticky output.

module count_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    input  logic             clr,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] error_count,
`ifdef COUNT_CHECKER_STICKY_EN
    output logic             err_sticky,
`endif
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // good_cnt only has to reach LOCK_LEN, which is at most 15
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       good_cnt;
    logic [3:0]       good_cnt_nxt;
    logic [WIDTH-1:0] prev_value;
    logic             prev_en;
    logic             mismatch;
    logic             locked_mismatch;
    logic             err_nxt;
    logic [ERR_W-1:0] error_count_nxt;

    // Prediction is built purely from registered samples, so the expected
    // output never has a combinational path from value/enable.
    assign expected = prev_value + {{(WIDTH-1){1'b0}}, prev_en};

    // Compare the live sample against the prediction; only meaningful
    // outside IDLE, where the prediction has been primed.
    always_comb begin
        mismatch        = (value != expected);
        locked_mismatch = (state == S_LOCKED) && mismatch;
    end

    // Sample history: the counter value and its enable from the last edge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_value <= '0;
            prev_en    <= 1'b0;
        end else begin
            prev_value <= value;
            prev_en    <= enable;
        end
    end

    // FSM state register together with the good-transition counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    // FSM next-state: IDLE primes the prediction, ACQ counts good
    // transitions up to LOCK_LEN, LOCKED drops back to ACQ on any miss.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt    = S_ACQ;
                good_cnt_nxt = '0;
            end
            S_ACQ: begin
                if (mismatch) begin
                    good_cnt_nxt = '0;
                end else begin
                    good_cnt_nxt = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 >= LOCK_TARGET) begin
                        state_nxt = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (mismatch) begin
                    state_nxt    = S_ACQ;
                    good_cnt_nxt = '0;
                    err_nxt      = 1'b1;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                good_cnt_nxt = '0;
            end
        endcase
    end

    // FSM outputs: locked follows the registered state directly
    always_comb begin
        locked = (state == S_LOCKED);
    end

    // Error pulse register: high for the single cycle after a LOCKED miss
    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else begin
            error <= err_nxt;
        end
    end

    // Error counter update: a coincident miss wins over clr so the miss
    // that happened on the clearing edge is still accounted for.
    always_comb begin
        error_count_nxt = error_count;
        if (locked_mismatch) begin
            if (clr) begin
                error_count_nxt = {{(ERR_W-1){1'b0}}, 1'b1};
            end else if (error_count != {ERR_W{1'b1}}) begin
                error_count_nxt = error_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end else if (clr) begin
            error_count_nxt = '0;
        end
    end

    // Error counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            error_count <= '0;
        end else begin
            error_count <= error_count_nxt;
        end
    end

`ifdef COUNT_CHECKER_STICKY_EN
    // Sticky flag: any LOCKED miss sets it, only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (locked_mismatch) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - directed self-checking bench for count_checker

module tb_count_checker;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    logic       enable;
    logic       clr;
    logic       locked;
    logic       error;
    logic [7:0] error_count;
    logic [7:0] expected;
`ifdef COUNT_CHECKER_STICKY_EN
    logic       err_sticky;
`endif

    int n_cmp;
    int n_err;
    logic [7:0] cnt;

    count_checker #(.WIDTH(8), .LOCK_LEN(4), .ERR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .enable      (enable),
        .clr         (clr),
        .locked      (locked),
        .error       (error),
        .error_count (error_count),
`ifdef COUNT_CHECKER_STICKY_EN
        .err_sticky  (err_sticky),
`endif
        .expected    (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [7:0] v, input logic en, input logic c);
        value  = v;
        enable = en;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(8'h5A, 1'b1, 1'b1);
        step(8'h5A, 1'b1, 1'b0);
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b need 0", locked); end
        n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL reset_error got %b need 0", error); end
        n_cmp++; if (error_count !== 8'h00) begin n_err++; $display("FAIL reset_count got %h need 00", error_count); end
        n_cmp++; if (expected !== 8'h00) begin n_err++; $display("FAIL reset_expected got %h need 00", expected); end
        reset = 1'b0;
    endtask

    task automatic test_lock;
        cnt = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
            n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL lock_error[%0d] got %b need 0", i, error); end
            n_cmp++; if (locked !== (i == 4)) begin n_err++; $display("FAIL lock_locked[%0d] got %b need %b", i, locked, (i == 4)); end
        end
        n_cmp++; if (expected !== 8'h05) begin n_err++; $display("FAIL lock_expected got %h need 05", expected); end
    endtask

    task automatic relock_from(input logic [7:0] start);
        reset = 1'b1;
        step(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        cnt = start;
        for (int i = 0; i < 5; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
        end
    endtask

    task automatic test_wrap;
        relock_from(8'hF8);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL wrap_prelock got %b need 1", locked); end
        for (int i = 0; i < 5; i++) begin
            step(cnt, 1'b1, 1'b0);
            n_cmp++; if (error !== 1'b0 || locked !== 1'b1) begin n_err++; $display("FAIL wrap[%h] error=%b locked=%b need error=0 locked=1", cnt, error, locked); end
            if (cnt == 8'hFF) begin
                n_cmp++; if (expected !== 8'h00) begin n_err++; $display("FAIL wrap_expected got %h need 00", expected); end
            end
            cnt = cnt + 8'd1;
        end
    endtask

    task automatic test_mismatch;
        relock_from(8'h0B);
        n_cmp++; if (expected !== 8'h10 || locked !== 1'b1) begin n_err++; $display("FAIL mm_pre expected=%h locked=%b need 10/1", expected, locked); end
        step(8'h20, 1'b1, 1'b0);
        n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL mm_error got %b need 1", error); end
        n_cmp++; if (error_count !== 8'h01) begin n_err++; $display("FAIL mm_count got %h need 01", error_count); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL mm_locked got %b need 0", locked); end
        n_cmp++; if (expected !== 8'h21) begin n_err++; $display("FAIL mm_expected got %h need 21", expected); end
`ifdef COUNT_CHECKER_STICKY_EN
        n_cmp++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL mm_sticky got %b need 1", err_sticky); end
`endif
        // A miss while re-acquiring is silent and restarts the good count
        step(8'h40, 1'b1, 1'b0);
        n_cmp++; if (error !== 1'b0 || error_count !== 8'h01) begin n_err++; $display("FAIL mm_acq_miss error=%b count=%h need 0/01", error, error_count); end
        cnt = 8'h41;
        for (int i = 0; i < 4; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
            n_cmp++; if (locked !== (i == 3) || error !== 1'b0) begin n_err++; $display("FAIL mm_relock[%0d] locked=%b error=%b need %b/0", i, locked, error, (i == 3)); end
        end
    endtask

    task automatic test_hold;
        logic       ens [5];
        logic [7:0] vals[5];
        ens  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vals = '{8'h45, 8'h46, 8'h46, 8'h46, 8'h47};
        for (int i = 0; i < 5; i++) begin
            step(vals[i], ens[i], 1'b0);
            n_cmp++; if (error !== 1'b0 || locked !== 1'b1) begin n_err++; $display("FAIL hold[%0d] error=%b locked=%b need 0/1", i, error, locked); end
        end
        n_cmp++; if (error_count !== 8'h01) begin n_err++; $display("FAIL hold_count got %h need 01", error_count); end
        n_cmp++; if (expected !== 8'h48) begin n_err++; $display("FAIL hold_expected got %h need 48", expected); end
        cnt = 8'h48;
        step(cnt, 1'b1, 1'b1);
        cnt = cnt + 8'd1;
        n_cmp++; if (error_count !== 8'h00 || locked !== 1'b1) begin n_err++; $display("FAIL clr_plain count=%h locked=%b need 00/1", error_count, locked); end
    endtask

    task automatic miss_and_relock(input logic c);
        step(cnt ^ 8'h80, 1'b1, c);
        cnt = (cnt ^ 8'h80) + 8'd1;
        for (int i = 0; i < 4; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
        end
    endtask

    task automatic test_clr_mismatch;
        for (int k = 1; k <= 5; k++) begin
            miss_and_relock(1'b0);
        end
        n_cmp++; if (error_count !== 8'h05 || locked !== 1'b1) begin n_err++; $display("FAIL clrmm_pre count=%h locked=%b need 05/1", error_count, locked); end
        step(cnt ^ 8'h80, 1'b1, 1'b1);
        cnt = (cnt ^ 8'h80) + 8'd1;
        n_cmp++; if (error_count !== 8'h01) begin n_err++; $display("FAIL clrmm_count got %h need 01", error_count); end
        n_cmp++; if (error !== 1'b1 || locked !== 1'b0) begin n_err++; $display("FAIL clrmm_flags error=%b locked=%b need 1/0", error, locked); end
        for (int i = 0; i < 4; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 256; k++) begin
            miss_and_relock(1'b0);
        end
        n_cmp++; if (error_count !== 8'hFF) begin n_err++; $display("FAIL sat_count got %h need ff", error_count); end
        step(cnt ^ 8'h80, 1'b1, 1'b0);
        cnt = (cnt ^ 8'h80) + 8'd1;
        n_cmp++; if (error !== 1'b1 || error_count !== 8'hFF) begin n_err++; $display("FAIL sat_pulse error=%b count=%h need 1/ff", error, error_count); end
        for (int i = 0; i < 4; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
        end
    endtask

    task automatic test_reset_mid;
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL rmid_pre locked got %b need 1", locked); end
        reset = 1'b1;
        step(cnt ^ 8'h80, 1'b1, 1'b0);
        reset = 1'b0;
        n_cmp++; if (locked !== 1'b0 || error !== 1'b0 || error_count !== 8'h00 || expected !== 8'h00) begin
            n_err++; $display("FAIL rmid_outputs locked=%b error=%b count=%h expected=%h need 0/0/00/00", locked, error, error_count, expected);
        end
`ifdef COUNT_CHECKER_STICKY_EN
        n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL rmid_sticky got %b need 0", err_sticky); end
`endif
        step(8'h77, 1'b1, 1'b0);
        n_cmp++; if (error !== 1'b0 || locked !== 1'b0 || expected !== 8'h78) begin n_err++; $display("FAIL rmid_first error=%b locked=%b expected=%h need 0/0/78", error, locked, expected); end
        cnt = 8'h78;
        for (int i = 0; i < 4; i++) begin
            step(cnt, 1'b1, 1'b0);
            cnt = cnt + 8'd1;
        end
        n_cmp++; if (locked !== 1'b1 || error_count !== 8'h00) begin n_err++; $display("FAIL rmid_relock locked=%b count=%h need 1/00", locked, error_count); end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        value  = 8'h00;
        enable = 1'b0;
        clr    = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_mismatch();
        test_hold();
        test_clr_mismatch();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter WIDTH, default 8: width of the monitored count value.
REQ-002 Parameter LOCK_LEN, default 4: consecutive good transitions required to reach LOCKED; legal range 1..15.
REQ-003 Parameter ERR_W, default 8: width of error_count.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port value, input, WIDTH: count value under test, driven by the counter.
REQ-007 Port enable, input, 1: the same enable that drives the counter.
REQ-008 Port clr, input, 1: synchronous clear of error_count.
REQ-009 Port locked, output, 1: high while the state is LOCKED.
REQ-010 Port error, output, 1: one-cycle pulse per mismatch detected in LOCKED.
REQ-011 Port error_count, output, ERR_W: saturating count of LOCKED mismatches.
REQ-012 Port expected, output, WIDTH: registered prediction of the next value.

Function
REQ-013 Each edge registers prev_value <= value and prev_en <= enable.
REQ-014 Prediction: expected = prev_value + prev_en, modulo 2^WIDTH.
- 0xFF with prev_en=1 predicts 0x00.
- prev_en=0 predicts a hold.
REQ-015 Transition is good when value == expected; otherwise it is a mismatch.
REQ-016 State IDLE: the first edge after reset captures value/enable and moves to ACQ with good_cnt=0; no comparison is made in IDLE.
REQ-017 State ACQ:
- good transition: good_cnt increments; on reaching LOCK_LEN, the state moves to LOCKED the same edge.
- mismatch: good_cnt <= 0, stay in ACQ, no error, no error_count change.
REQ-018 State LOCKED:
- good transition: stay in LOCKED.
- mismatch: error <= 1 for exactly one cycle, error_count increments, state <= ACQ, good_cnt <= 0.
REQ-019 Latency: a mismatching value sampled at edge N produces error high from edge N to edge N+1 and locked low from edge N.
REQ-020 Back-to-back mismatches in LOCKED are impossible (the state leaves LOCKED); re-lock requires LOCK_LEN fresh good transitions.
REQ-021 error_count saturates at 2^ERR_W-1; further mismatches still pulse error.
REQ-022 clr with no same-edge mismatch: error_count <= 0.
REQ-023 clr coincident with a LOCKED mismatch: error_count <= 1.
REQ-024 clr has no effect on state, locked, error, or expected.
REQ-025 The enable and value inputs are used only as sampled; no combinational path from inputs to outputs.

Reset
REQ-026 With reset high at an edge:
- state <= IDLE, good_cnt <= 0.
- locked <= 0, error <= 0, error_count <= 0, expected <= 0.
- prev_value <= 0, prev_en <= 0.
REQ-027 Reset has priority over clr and every state transition, including a mismatch on the same edge.
REQ-028 Reset asserted mid-LOCKED for one cycle returns the block to IDLE; the next sampled value is captured without comparison.

Configuration
REQ-029 Macro COUNT_CHECKER_STICKY_EN, when defined:
- adds output err_sticky, 1 bit.
- err_sticky is set by any LOCKED mismatch and cleared only by reset; clr does not clear it.
REQ-030 Without COUNT_CHECKER_STICKY_EN, err_sticky is absent from the port list and all other behaviour is identical.

Verification
REQ-031 Reset, then enable=1 with counter ramping from 0x00 -> locked=1 after the 5th sampled value (LOCK_LEN=4); error stays 0.
REQ-032 Locked ramp crossing 0xFE, 0xFF, 0x00, 0x01 -> no error; locked stays 1.
REQ-033 Locked at 0x10 with enable=1, value forced to 0x20 -> error pulses 1 cycle, error_count=1, locked=0, re-lock after 4 good transitions.
REQ-034 enable toggled 1,0,0,1 while locked; value holds correctly -> no error; with STICKY_EN defined, err_sticky stays 0.
REQ-035 clr asserted on the same edge as a LOCKED mismatch with error_count=5 -> error_count=1.
REQ-036 Reset pulsed for 1 cycle while locked -> outputs return to reset values; no error on the first post-reset value, even if it is discontinuous.
